// File: rtl/sort_stream_pkg.sv
// Shared types and constants for the streaming character/weight sorter.
// Weight is the major ranking key, character the tie-breaker.
package sort_stream_pkg;

  localparam int unsigned CHAR_W_DEF = 4;
  localparam int unsigned WGT_W_DEF  = 5;
  localparam int unsigned KEY_MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CHAR_W_DEF-1:0] character;
    logic [WGT_W_DEF-1:0]  weight;
  } pair_t;

  // Keys are {weight, character}, so one unsigned compare gives the full ranking.
  function automatic logic ranks_above(input logic [KEY_MAX_W-1:0] key_a,
                                       input logic [KEY_MAX_W-1:0] key_b);
    return key_a > key_b;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange cell: routes the higher-ranked pair to hi,
// the other to lo, and flags when the inputs were out of order.
module sort_cmp_swap
  import sort_stream_pkg::*;
#(
  parameter int unsigned CHAR_W = CHAR_W_DEF,
  parameter int unsigned WGT_W  = WGT_W_DEF
) (
  input  logic [CHAR_W-1:0] a_char_i,
  input  logic [WGT_W-1:0]  a_wgt_i,
  input  logic [CHAR_W-1:0] b_char_i,
  input  logic [WGT_W-1:0]  b_wgt_i,
  output logic [CHAR_W-1:0] hi_char_o,
  output logic [WGT_W-1:0]  hi_wgt_o,
  output logic [CHAR_W-1:0] lo_char_o,
  output logic [WGT_W-1:0]  lo_wgt_o,
  output logic              swapped_o
);

  logic [KEY_MAX_W-1:0] key_a;
  logic [KEY_MAX_W-1:0] key_b;

  assign key_a     = KEY_MAX_W'({a_wgt_i, a_char_i});
  assign key_b     = KEY_MAX_W'({b_wgt_i, b_char_i});
  assign swapped_o = ranks_above(key_b, key_a);

  assign hi_char_o = swapped_o ? b_char_i : a_char_i;
  assign hi_wgt_o  = swapped_o ? b_wgt_i  : a_wgt_i;
  assign lo_char_o = swapped_o ? a_char_i : b_char_i;
  assign lo_wgt_o  = swapped_o ? a_wgt_i  : b_wgt_i;

endmodule

// File: rtl/sort_stream_engine.sv
// Streaming sorter: loads up to DEPTH pairs, odd-even transposition sorts them
// one pass per cycle, then streams them out descending. Option: SORT_EARLY_EXIT_EN.
module sort_stream_engine
  import sort_stream_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CHAR_W = CHAR_W_DEF,
  parameter int unsigned WGT_W  = WGT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [CHAR_W-1:0] in_character,
  input  logic [WGT_W-1:0]  in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CHAR_W-1:0] out_character,
  output logic [WGT_W-1:0]  out_weight,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PASS_W = $clog2(DEPTH);
  localparam int unsigned NCELL  = DEPTH / 2;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [CHAR_W-1:0]   chr_q [DEPTH];
  logic [CHAR_W-1:0]   chr_d [DEPTH];
  logic [WGT_W-1:0]    wgt_q [DEPTH];
  logic [WGT_W-1:0]    wgt_d [DEPTH];
`ifdef SORT_EARLY_EXIT_EN
  logic                even_clean_q, even_clean_d;
`endif

  logic                odd_pass;
  logic [CHAR_W-1:0]   a_c  [NCELL];
  logic [WGT_W-1:0]    a_w  [NCELL];
  logic [CHAR_W-1:0]   b_c  [NCELL];
  logic [WGT_W-1:0]    b_w  [NCELL];
  logic [CHAR_W-1:0]   hi_c [NCELL];
  logic [WGT_W-1:0]    hi_w [NCELL];
  logic [CHAR_W-1:0]   lo_c [NCELL];
  logic [WGT_W-1:0]    lo_w [NCELL];
  logic [NCELL-1:0]    cell_sw;
  logic [CHAR_W-1:0]   rd_char;
  logic [WGT_W-1:0]    rd_wgt;

  assign odd_pass = pass_q[0];

  // On odd passes a trailing cell with no partner compares a slot with itself.
  for (genvar k = 0; k < NCELL; k++) begin : g_cell
    localparam int unsigned OA = 2 * k + 1;
    localparam int unsigned OB = (2 * k + 2 < DEPTH) ? 2 * k + 2 : 2 * k + 1;

    assign a_c[k] = odd_pass ? chr_q[OA] : chr_q[2*k];
    assign a_w[k] = odd_pass ? wgt_q[OA] : wgt_q[2*k];
    assign b_c[k] = odd_pass ? chr_q[OB] : chr_q[2*k+1];
    assign b_w[k] = odd_pass ? wgt_q[OB] : wgt_q[2*k+1];

    sort_cmp_swap #(
      .CHAR_W (CHAR_W),
      .WGT_W  (WGT_W)
    ) u_cell (
      .a_char_i  (a_c[k]),
      .a_wgt_i   (a_w[k]),
      .b_char_i  (b_c[k]),
      .b_wgt_i   (b_w[k]),
      .hi_char_o (hi_c[k]),
      .hi_wgt_o  (hi_w[k]),
      .lo_char_o (lo_c[k]),
      .lo_wgt_o  (lo_w[k]),
      .swapped_o (cell_sw[k])
    );
  end

`ifndef SORT_EARLY_EXIT_EN
  logic unused_swap;
  assign unused_swap = |cell_sw;
`endif

  always_comb begin
    rd_char = '0;
    rd_wgt  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == CNT_W'(i)) begin
        rd_char = chr_q[i];
        rd_wgt  = wgt_q[i];
      end
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign out_valid     = (state_q == OUT);
  assign out_last      = out_valid && (rd_ptr_q == count_q - CNT_W'(1));
  assign out_character = out_valid ? rd_char : '0;
  assign out_weight    = out_valid ? rd_wgt  : '0;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    chr_d    = chr_q;
    wgt_d    = wgt_q;
`ifdef SORT_EARLY_EXIT_EN
    even_clean_d = even_clean_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i)) begin
              chr_d[i] = in_character;
              wgt_d[i] = in_weight;
            end
          end
          count_d = count_q + CNT_W'(1);
          if (in_last || count_q == CNT_W'(DEPTH - 1)) begin
            state_d = SORT;
            pass_d  = '0;
`ifdef SORT_EARLY_EXIT_EN
            even_clean_d = 1'b0;
`endif
          end
        end
      end
      SORT: begin
        for (int unsigned k = 0; k < NCELL; k++) begin
          if (!odd_pass) begin
            chr_d[2*k]   = hi_c[k];
            wgt_d[2*k]   = hi_w[k];
            chr_d[2*k+1] = lo_c[k];
            wgt_d[2*k+1] = lo_w[k];
          end else if (2 * k + 2 < DEPTH) begin
            chr_d[2*k+1] = hi_c[k];
            wgt_d[2*k+1] = hi_w[k];
            chr_d[2*k+2] = lo_c[k];
            wgt_d[2*k+2] = lo_w[k];
          end
        end
        pass_d = pass_q + PASS_W'(1);
        if (pass_q == PASS_W'(DEPTH - 1)) begin
          state_d  = OUT;
          rd_ptr_d = '0;
          pass_d   = '0;
        end
`ifdef SORT_EARLY_EXIT_EN
        // A clean even pass followed by a clean odd pass means every
        // adjacent pair is already ordered.
        else if (odd_pass && (cell_sw == '0) && even_clean_q) begin
          state_d  = OUT;
          rd_ptr_d = '0;
          pass_d   = '0;
        end
        even_clean_d = !odd_pass && (cell_sw == '0);
`endif
      end
      OUT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d  = IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
              chr_d[i] = '0;
              wgt_d[i] = '0;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        chr_q[i] <= '0;
        wgt_q[i] <= '0;
      end
`ifdef SORT_EARLY_EXIT_EN
      even_clean_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      chr_q    <= chr_d;
      wgt_q    <= wgt_d;
`ifdef SORT_EARLY_EXIT_EN
      even_clean_q <= even_clean_d;
`endif
    end
  end

endmodule

// File: tb/tb_sort_stream_engine.sv
// Self-checking bench for sort_stream_engine: table of batches with expected
// sorted order and latency, scoreboard on the output stream, plus corner sequences.
module tb_sort_stream_engine;
  import sort_stream_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned WW    = 5;
  localparam int          NV    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [CW-1:0] in_character;
  logic [WW-1:0] in_weight;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] out_character;
  logic [WW-1:0] out_weight;
  logic          busy;

  always #5 clk = ~clk;

  sort_stream_engine #(
    .DEPTH  (DEPTH),
    .CHAR_W (CW),
    .WGT_W  (WW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_character  (in_character),
    .in_weight     (in_weight),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_character (out_character),
    .out_weight    (out_weight),
    .busy          (busy)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [WW-1:0] w;
    logic          last;
  } exp_t;

  typedef struct {
    int          n;
    logic        use_last;
    pair_t [7:0] in_p;
    pair_t [7:0] exp_p;
    int          lat_plain;
    int          lat_early;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs [NV];

  function automatic pair_t mk(input int c, input int w);
    pair_t p;
    p.character = CW'(c);
    p.weight    = WW'(w);
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got pair (%0d,%0d), expected no output",
                 out_character, out_weight);
      end else begin
        e = sb.pop_front();
        check("out_character", out_character, e.c);
        check("out_weight", out_weight, e.w);
        check("out_last", out_last, e.last);
      end
    end
  end

  task automatic send_pair(input logic [CW-1:0] c, input logic [WW-1:0] w, input logic last);
    int guard;
    guard        = 0;
    in_valid     = 1'b1;
    in_character = c;
    in_weight    = w;
    in_last      = last;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("in_ready_wait", 0, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_expected(input vec_t v);
    for (int i = 0; i < v.n; i++)
      sb.push_back('{c: v.exp_p[i].character, w: v.exp_p[i].weight, last: 1'(i == v.n - 1)});
  endtask

  task automatic send_batch(input vec_t v);
    for (int i = 0; i < v.n; i++)
      send_pair(v.in_p[i].character, v.in_p[i].weight, v.use_last && (i == v.n - 1));
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    check("latency", lat, exp_lat);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("scoreboard_empty", sb.size(), 0);
    tick();
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  function automatic int pick_lat(input vec_t v);
`ifdef SORT_EARLY_EXIT_EN
    return v.lat_early;
`else
    return v.lat_plain;
`endif
  endfunction

  initial begin : timeout
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    vec_t v;
    for (int t = 0; t < NV; t++) begin
      vecs[t].in_p     = '0;
      vecs[t].exp_p    = '0;
      vecs[t].use_last = 1'b1;
    end
    // Reverse order: ascending weights in, descending out.
    vecs[0].n = 8; vecs[0].lat_plain = 8; vecs[0].lat_early = 8;
    for (int i = 0; i < 8; i++) begin
      vecs[0].in_p[i]  = mk(i, i + 1);
      vecs[0].exp_p[i] = mk(7 - i, 8 - i);
    end
    // Equal weights: character breaks the tie.
    vecs[1].n = 3; vecs[1].lat_plain = 8; vecs[1].lat_early = 4;
    vecs[1].in_p[0]  = mk(3, 5); vecs[1].in_p[1]  = mk(9, 5); vecs[1].in_p[2]  = mk(1, 5);
    vecs[1].exp_p[0] = mk(9, 5); vecs[1].exp_p[1] = mk(3, 5); vecs[1].exp_p[2] = mk(1, 5);
    // Short batch containing zero-weight entries.
    vecs[2].n = 3; vecs[2].lat_plain = 8; vecs[2].lat_early = 4;
    vecs[2].in_p[0]  = mk(2, 0); vecs[2].in_p[1]  = mk(5, 7); vecs[2].in_p[2]  = mk(4, 0);
    vecs[2].exp_p[0] = mk(5, 7); vecs[2].exp_p[1] = mk(4, 0); vecs[2].exp_p[2] = mk(2, 0);
    // Already descending, batch closed by reaching DEPTH rather than in_last.
    vecs[3].n = 8; vecs[3].use_last = 1'b0; vecs[3].lat_plain = 8; vecs[3].lat_early = 2;
    for (int i = 0; i < 8; i++) begin
      vecs[3].in_p[i]  = mk(i, 8 - i);
      vecs[3].exp_p[i] = mk(i, 8 - i);
    end
    // Mixed batch.
    vecs[4].n = 6; vecs[4].lat_plain = 8; vecs[4].lat_early = 8;
    vecs[4].in_p[0] = mk(10, 3); vecs[4].in_p[1] = mk(2, 9);  vecs[4].in_p[2] = mk(7, 3);
    vecs[4].in_p[3] = mk(15, 0); vecs[4].in_p[4] = mk(0, 31); vecs[4].in_p[5] = mk(5, 9);
    vecs[4].exp_p[0] = mk(0, 31); vecs[4].exp_p[1] = mk(5, 9); vecs[4].exp_p[2] = mk(2, 9);
    vecs[4].exp_p[3] = mk(10, 3); vecs[4].exp_p[4] = mk(7, 3); vecs[4].exp_p[5] = mk(15, 0);

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    in_character = '0;
    in_weight    = '0;
    out_ready    = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_character", out_character, 0);
    check("rst_out_weight", out_weight, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < NV; t++) begin
      v = vecs[t];
      push_expected(v);
      send_batch(v);
      check("in_ready_drop", in_ready, 0);
      check("busy_sort", busy, 1);
      wait_out(pick_lat(v));
      drain();
    end

    // Backpressure mid-stream, with in_valid pulsed during SORT and OUT.
    v = vecs[4];
    push_expected(v);
    send_batch(v);
    in_valid     = 1'b1;
    in_character = 4'd15;
    in_weight    = 5'd31;
    for (int i = 0; i < 2; i++) begin
      check("sort_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    wait_out(pick_lat(v) - 2);
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_out_character", out_character, sb[0].c);
      check("hold_out_weight", out_weight, sb[0].w);
      check("out_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during pass 3 of a full batch, then a fresh 2-pair batch.
    send_batch(vecs[0]);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    sb.push_back('{c: 4'd6, w: 5'd11, last: 1'b0});
    sb.push_back('{c: 4'd4, w: 5'd2,  last: 1'b1});
    send_pair(4'd4, 5'd2, 1'b0);
    send_pair(4'd6, 5'd11, 1'b1);
`ifdef SORT_EARLY_EXIT_EN
    wait_out(4);
`else
    wait_out(8);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
